pcie_rq_arbiter: RTL
====================

# pcie_rq_arbiter

Packet-atomic N-source arbiter for the root-port requester-request (RQ) AXI4-Stream path. It is the parametrised successor of the two-input configurator Tx mux and sits between the configurator, the user request sources and the root-port wrapper RQ interface. Source 0 is reserved for the configurator and gated by `config_mode`. Sources 1..NUM_SRC-1 share the link by round-robin at packet granularity; a packet is never interleaved with another.

## Interface

Parameters:
- `NUM_SRC`, 4: number of request sources, range 2..16. Source 0 is the configurator.
- `C_DATA_WIDTH`, 128: RQ tdata width.
- `KEEP_WIDTH`, C_DATA_WIDTH/32: tkeep width.
- `AXI4_RQ_TUSER_WIDTH`, 62: tuser width.
- `SRC_IDX_WIDTH`, clog2(NUM_SRC) with a minimum of 1: width of the grant index.

Ports:
- `user_clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `config_mode`, in, 1: request from the controller to own the link.
- `config_mode_active`, out, 1: the link is owned by source 0.
- `s_axis_rq_tdata`, in, NUM_SRC*C_DATA_WIDTH: source data. Source i occupies slice [i*W +: W].
- `s_axis_rq_tkeep`, in, NUM_SRC*KEEP_WIDTH: source tkeep, sliced the same way.
- `s_axis_rq_tuser`, in, NUM_SRC*AXI4_RQ_TUSER_WIDTH: source tuser, sliced the same way.
- `s_axis_rq_tlast`, in, NUM_SRC: per-source last-beat flag.
- `s_axis_rq_tvalid`, in, NUM_SRC: per-source valid.
- `s_axis_rq_tready`, out, NUM_SRC: per-source ready.
- `m_axis_rq_tdata`, out, C_DATA_WIDTH: data toward the root-port wrapper.
- `m_axis_rq_tkeep`, out, KEEP_WIDTH: tkeep toward the root-port wrapper.
- `m_axis_rq_tuser`, out, AXI4_RQ_TUSER_WIDTH: tuser toward the root-port wrapper.
- `m_axis_rq_tlast`, out, 1: last beat toward the root-port wrapper.
- `m_axis_rq_tvalid`, out, 1: valid toward the root-port wrapper.
- `m_axis_rq_tready`, in, 1: ready from the root-port wrapper.
- `grant_idx`, out, SRC_IDX_WIDTH: the currently granted source.
- `busy`, out, 1: a packet is in flight (state LOCK).

## Operation

- **Eligibility**
  - When `config_mode`=1, only source 0 is eligible.
  - When `config_mode`=0, sources 1..NUM_SRC-1 are eligible and source 0 is blocked.
- **States**
  - IDLE: no grant. All s_tready=0, m_tvalid=0.
    - If any eligible source has tvalid, the round-robin picker selects the first eligible valid source, searching from `last_grant`+1 modulo NUM_SRC.
    - The selection is registered into `grant_idx` and `last_grant`, and the state moves to LOCK at the next edge.
  - LOCK:
    - The granted source's data, keep, user, last and valid are routed combinationally to the m_ side.
    - `s_axis_rq_tready[grant_idx]` = `m_axis_rq_tready`. All other s_tready=0.
    - A beat with m_tvalid & m_tready & m_tlast returns the state to IDLE at that edge.
- **Config-mode changes**
  - A change of `config_mode` during LOCK does not pre-empt the packet. It takes effect at the next IDLE arbitration.
- **`config_mode_active`**
  - Registered.
  - Set to 1 when `config_mode`=1 and the state is IDLE, or when the current packet is from source 0.
  - Cleared in the cycle after `config_mode` falls, once no source-0 packet is in flight.
  - The controller does not issue TLPs until it sees this flag set.
- **Bus stability**
  - m_* data, keep, user and last are zero whenever m_tvalid=0. This keeps the bus quiet for ILA capture.
- **Round-robin fairness**
  - `last_grant` is updated only on a grant.
  - A source that keeps tvalid held high waits at most NUM_SRC-2 other user packets before it is served.

## Timing

- **Reset values:** state=IDLE, `grant_idx`=0, `last_grant`=NUM_SRC-1, `busy`=0, `config_mode_active`=0, all s_tready=0, m_tvalid=0, m_* data, keep, user and last = 0.
- **Arbitration latency:** one cycle from tvalid seen in IDLE to the first beat presented in LOCK.
- **Inter-packet gap:** one bubble cycle between consecutive packets, even from the same source.
- **Throughput within a packet:** one beat per cycle while m_tready=1. Data path latency from s to m is 0 cycles.
- **m_tready low:** the granted s_tready follows it low. The granted source must hold its beat; the arbiter holds its grant.
- **Single-beat packets** (tlast on the first beat): LOCK lasts exactly one accepted cycle.
- **Source drops tvalid mid-packet:** m_tvalid=0. The state stays LOCK and the grant is held, with no timeout.
- **Wrap-around:** when `last_grant`=NUM_SRC-1, the search continues from 0. Source 0 is skipped unless `config_mode`=1.
- **Reset mid-packet:** the packet is abandoned. All outputs return to their reset values at the next edge.

## Structure

- Package `pcie_cfg_pkg` holds:
  - the state encoding (IDLE=1'b0, LOCK=1'b1);
  - the `clog2` function used for SRC_IDX_WIDTH;
  - the source-0 index constant `CFG_SRC_IDX`=0.
- Sub-module `pcie_rr_pick`, parametrised by NUM_SRC:
  - purely combinational;
  - inputs: request vector and `last_grant`;
  - outputs: a `found` flag and the selected index, using priority rotation.
- The top contains the FSM, the grant registers and the output mux.

## Test plan

- **Reset and single source:** after reset, source 1 sends a 3-beat packet with m_tready=1. Required: m_tvalid rises 1 cycle after s_tvalid[1]; 3 consecutive beats appear; `grant_idx`=1; `busy` falls after the tlast beat.
- **Round-robin order:** NUM_SRC=4, sources 1, 2 and 3 continuously valid with 2-beat packets. Required: grant order 1, 2, 3, 1, 2, 3, with one bubble cycle between packets.
- **Config hand-off:** `config_mode` rises while source 2 is mid-packet (beat 2 of 4). Required: source 2 finishes all 4 beats; the next grant is 0; `config_mode_active`=1 before source 0's first beat.
- **Backpressure:** m_tready toggles 1, 0, 0, 1 during a 4-beat packet. Required: `s_axis_rq_tready[grant]` mirrors m_tready; beats are neither duplicated nor lost; the other s_tready stay 0.
- **Reset mid-packet:** reset is asserted on beat 2 of 5 from source 3. Required: at the next edge m_tvalid=0, `busy`=0 and `grant_idx`=0. After reset release, source 3 is re-arbitrated from IDLE.
- **Wrap and skip:** `last_grant`=3, `config_mode`=0, sources 0 and 1 valid. Required: the grant goes to 1 and source 0's tready stays 0.

Source files
------------

// File: rtl/pcie_cfg_pkg.sv
// pcie_cfg_pkg: shared state encoding, index helper and source-0 constant for the RQ arbiter.
package pcie_cfg_pkg;

    typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_e;

    localparam int CFG_SRC_IDX = 0;

    // Index width for n sources, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/pcie_rr_pick.sv
// pcie_rr_pick: combinational round-robin picker, first request after last_i wins.
module pcie_rr_pick
    import pcie_cfg_pkg::*;
#(
    parameter int NUM_SRC = 4,
    localparam int IW = clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic               found_o,
    output logic [IW-1:0]      idx_o
);

    logic [IW-1:0] j;

    // Walk from the farthest to the nearest candidate so the nearest one is written last.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        j       = '0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            j = IW'((int'(last_i) + k) % NUM_SRC);
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o   = j;
            end
        end
    end

endmodule

// File: rtl/pcie_rq_arbiter.sv
// pcie_rq_arbiter: packet-atomic N-source arbiter for the root-port RQ AXI4-Stream path.
module pcie_rq_arbiter
    import pcie_cfg_pkg::*;
#(
    parameter int NUM_SRC             = 4,
    parameter int C_DATA_WIDTH        = 128,
    parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
    parameter int AXI4_RQ_TUSER_WIDTH = 62,
    parameter int SRC_IDX_WIDTH       = clog2(NUM_SRC)
) (
    input  logic                                   user_clk,
    input  logic                                   reset,
    input  logic                                   config_mode,
    output logic                                   config_mode_active,
    input  logic [NUM_SRC*C_DATA_WIDTH-1:0]        s_axis_rq_tdata,
    input  logic [NUM_SRC*KEEP_WIDTH-1:0]          s_axis_rq_tkeep,
    input  logic [NUM_SRC*AXI4_RQ_TUSER_WIDTH-1:0] s_axis_rq_tuser,
    input  logic [NUM_SRC-1:0]                     s_axis_rq_tlast,
    input  logic [NUM_SRC-1:0]                     s_axis_rq_tvalid,
    output logic [NUM_SRC-1:0]                     s_axis_rq_tready,
    output logic [C_DATA_WIDTH-1:0]                m_axis_rq_tdata,
    output logic [KEEP_WIDTH-1:0]                  m_axis_rq_tkeep,
    output logic [AXI4_RQ_TUSER_WIDTH-1:0]         m_axis_rq_tuser,
    output logic                                   m_axis_rq_tlast,
    output logic                                   m_axis_rq_tvalid,
    input  logic                                   m_axis_rq_tready,
    output logic [SRC_IDX_WIDTH-1:0]               grant_idx,
    output logic                                   busy
);

    localparam int PW = clog2(NUM_SRC);

    state_e                   state_q, state_d;
    logic [SRC_IDX_WIDTH-1:0] grant_q, grant_d;
    logic [PW-1:0]            last_q, last_d, pick_idx;
    logic                     cma_q, cma_d, found;
    logic [NUM_SRC-1:0]       cfg_mask, req;
    logic                     lock;

    assign cfg_mask = NUM_SRC'(1) << CFG_SRC_IDX;
    assign req      = s_axis_rq_tvalid & (config_mode ? cfg_mask : ~cfg_mask);
    assign lock     = (state_q == LOCK);

    pcie_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req_i   (req),
        .last_i  (last_q),
        .found_o (found),
        .idx_o   (pick_idx)
    );

    // Zero the payload whenever valid is low so captures of the bus stay quiet.
    always_comb begin
        m_axis_rq_tvalid = lock & s_axis_rq_tvalid[grant_q];
        m_axis_rq_tdata  = m_axis_rq_tvalid ? s_axis_rq_tdata[grant_q*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
        m_axis_rq_tkeep  = m_axis_rq_tvalid ? s_axis_rq_tkeep[grant_q*KEEP_WIDTH +: KEEP_WIDTH] : '0;
        m_axis_rq_tuser  = m_axis_rq_tvalid ? s_axis_rq_tuser[grant_q*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH] : '0;
        m_axis_rq_tlast  = m_axis_rq_tvalid & s_axis_rq_tlast[grant_q];
        s_axis_rq_tready = lock ? (NUM_SRC'(m_axis_rq_tready) << grant_q) : '0;
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cma_d   = lock ? (grant_q == SRC_IDX_WIDTH'(CFG_SRC_IDX)) : config_mode;
        if (!lock && found) begin
            state_d = LOCK;
            grant_d = SRC_IDX_WIDTH'(pick_idx);
            last_d  = pick_idx;
        end else if (lock && m_axis_rq_tvalid && m_axis_rq_tready && m_axis_rq_tlast) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge user_clk) begin
        if (reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= PW'(NUM_SRC - 1);
            cma_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cma_q   <= cma_d;
        end
    end

    assign grant_idx          = grant_q;
    assign busy               = lock;
    assign config_mode_active = cma_q;

endmodule
